// File: rtl/sap_ram_if.sv
// Bus bundle between the SAP CPU/host and the RAM controller.
// Carries CPU access, program-load stream and status signals.
interface sap_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ce_n;
  logic                  lr_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_oe;
  logic                  prog_en;
  logic                  prog_valid;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_ready;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic                  busy;

  modport master (
    output mar, data_in, ce_n, lr_n,
    output prog_en, prog_valid, prog_data,
    input  data_out, data_oe,
    input  prog_ready, prog_addr, busy
  );

  modport slave (
    input  mar, data_in, ce_n, lr_n,
    input  prog_en, prog_valid, prog_data,
    output data_out, data_oe,
    output prog_ready, prog_addr, busy
  );
endinterface

// File: rtl/sap_ram_ctrl.sv
// Single-port SAP RAM with registered read, reset-time zero fill
// and a streaming program-load port.
module sap_ram_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  sap_ram_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    PROG
  } state_t;

  localparam state_t RST_STATE =
    CLEAR_ON_RESET ? CLEAR : RUN;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] prog_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  // Exactly one write source per state feeds the single port.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = bus.mar;
    wdata     = bus.data_in;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_ptr;
        wdata = '0;
        if (clr_ptr == LAST) state_nxt = RUN;
      end
      RUN: begin
        we = ~bus.lr_n;
        if (bus.prog_en) state_nxt = PROG;
      end
      PROG: begin
        we    = bus.prog_valid;
        waddr = prog_ptr;
        wdata = bus.prog_data;
        if (!bus.prog_en) state_nxt = RUN;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr  <= '0;
      prog_ptr <= '0;
    end else begin
      if (state == CLEAR)
        clr_ptr <= clr_ptr + 1'b1;
      if (state == RUN && bus.prog_en)
        prog_ptr <= '0;
      else if (state == PROG && bus.prog_valid)
        prog_ptr <= prog_ptr + 1'b1;
    end
  end

  // A read issued while entering PROG still loads data_out but is not driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
    end else begin
      bus.data_oe <= 1'b0;
      if (state == RUN && bus.lr_n && !bus.ce_n) begin
        bus.data_out <= mem[bus.mar];
        bus.data_oe  <= ~bus.prog_en;
      end
    end
  end

  assign bus.busy       = (state != RUN);
  assign bus.prog_ready = (state == PROG);
  assign bus.prog_addr  = (state == PROG) ? prog_ptr : '0;

endmodule

// File: tb/tb_sap_ram_ctrl.sv
// Bench for sap_ram_ctrl: cycle model for the 8x16 clearing config
// plus directed checks of a 16x64 non-clearing instance.
module tb_sap_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sap_ram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) ia ();
  sap_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) ib ();

  sap_ram_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );

  sap_ram_ctrl #(
    .DATA_WIDTH(16), .ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [16];
  int         clear_left;
  bit         m_prog;
  int         m_ptr;
  logic [7:0] e_out;
  bit         e_oe;
  bit         chk_on = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Memory reads as all zero once the clear pass has run.
  function automatic void model_reset();
    e_out      = '0;
    e_oe       = 1'b0;
    m_prog     = 1'b0;
    m_ptr      = 0;
    clear_left = 16;
    foreach (m_mem[i]) m_mem[i] = '0;
  endfunction

  function automatic void model_step();
    if (rst) return;
    if (clear_left > 0) begin
      clear_left--;
      e_oe = 1'b0;
      return;
    end
    if (m_prog) begin
      if (ia.prog_valid) begin
        m_mem[m_ptr] = ia.prog_data;
        m_ptr = (m_ptr + 1) % 16;
      end
      if (!ia.prog_en) m_prog = 1'b0;
      e_oe = 1'b0;
      return;
    end
    if (!ia.lr_n) begin
      m_mem[ia.mar] = ia.data_in;
      e_oe = 1'b0;
    end else if (!ia.ce_n) begin
      e_out = m_mem[ia.mar];
      e_oe  = 1'b1;
    end else begin
      e_oe = 1'b0;
    end
    if (ia.prog_en) begin
      m_prog = 1'b1;
      m_ptr  = 0;
      e_oe   = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",       32'(ia.busy),       32'(clear_left > 0 || m_prog));
      check("prog_ready", 32'(ia.prog_ready), 32'(m_prog));
      check("prog_addr",  32'(ia.prog_addr),  m_prog ? m_ptr : 0);
      check("data_oe",    32'(ia.data_oe),    32'(e_oe));
      check("data_out",   32'(ia.data_out),   32'(e_out));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_a();
    int n;
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("b_busy_after_rst", 32'(ib.busy), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (ia.busy) n++;
      tick();
    end
    check("clear_cycles", n, 16);
  endtask

  task automatic rd(input int a);
    ia.ce_n = 1'b0;
    ia.mar  = 4'(a);
    tick();
    ia.ce_n = 1'b1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    ia.lr_n    = 1'b0;
    ia.mar     = 4'(a);
    ia.data_in = d;
    tick();
    ia.lr_n = 1'b1;
  endtask

  initial begin
    ia.mar = '0; ia.data_in = '0; ia.ce_n = 1'b1; ia.lr_n = 1'b1;
    ia.prog_en = 1'b0; ia.prog_valid = 1'b0; ia.prog_data = '0;
    ib.mar = '0; ib.data_in = '0; ib.ce_n = 1'b1; ib.lr_n = 1'b1;
    ib.prog_en = 1'b0; ib.prog_valid = 1'b0; ib.prog_data = '0;
    model_reset();
    chk_on = 1;

    reset_a();

    for (int i = 0; i < 16; i++) begin
      rd(i);
      check("clr_rd_oe", 32'(ia.data_oe), 1);
    end
    check("clr_rd15", 32'(ia.data_out), 0);

    wr(3, 8'hA5);
    rd(3);
    check("rd3_out", 32'(ia.data_out), 32'hA5);
    check("rd3_oe",  32'(ia.data_oe), 1);
    tick();
    check("idle_oe",   32'(ia.data_oe), 0);
    check("idle_hold", 32'(ia.data_out), 32'hA5);

    ia.lr_n = 1'b0; ia.ce_n = 1'b0;
    ia.mar = 4'd7; ia.data_in = 8'h3C;
    tick();
    ia.lr_n = 1'b1; ia.ce_n = 1'b1;
    check("both_oe", 32'(ia.data_oe), 0);
    rd(7);
    check("rd7_out", 32'(ia.data_out), 32'h3C);

    ia.prog_en = 1'b1;
    tick();
    check("prog_ready", 32'(ia.prog_ready), 1);
    tick();
    check("prog_idle_addr", 32'(ia.prog_addr), 0);
    ia.lr_n = 1'b0; ia.mar = 4'd5; ia.data_in = 8'hFF;
    for (int i = 0; i < 18; i++) begin
      ia.prog_valid = 1'b1;
      ia.prog_data  = 8'(8'h10 + i);
      if (i == 17) ia.prog_en = 1'b0;
      tick();
      if (i == 14) check("addr15", 32'(ia.prog_addr), 15);
      if (i == 15) check("addr_wrap", 32'(ia.prog_addr), 0);
    end
    ia.prog_valid = 1'b0;
    ia.lr_n = 1'b1;
    check("run_busy", 32'(ia.busy), 0);
    rd(0);  check("pg0",  32'(ia.data_out), 32'h20);
    rd(1);  check("pg1",  32'(ia.data_out), 32'h21);
    rd(2);  check("pg2",  32'(ia.data_out), 32'h12);
    rd(15); check("pg15", 32'(ia.data_out), 32'h1F);
    rd(5);  check("pg5",  32'(ia.data_out), 32'h15);

    ia.prog_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ia.prog_valid = 1'b1;
      ia.prog_data  = 8'(8'h40 + i);
      tick();
    end
    ia.prog_valid = 1'b0;
    check("mid_addr", 32'(ia.prog_addr), 5);
    ia.prog_en = 1'b0;
    reset_a();
    for (int i = 0; i < 16; i++) rd(i);
    rd(2);
    check("rst_rd2", 32'(ia.data_out), 0);
    check("rst_oe",  32'(ia.data_oe), 1);

    check("b_busy",  32'(ib.busy), 0);
    check("b_paddr", 32'(ib.prog_addr), 0);
    ib.lr_n = 1'b0; ib.mar = 6'd63; ib.data_in = 16'hBEEF;
    tick();
    check("b_wr_oe", 32'(ib.data_oe), 0);
    ib.lr_n = 1'b1; ib.ce_n = 1'b0;
    tick();
    ib.ce_n = 1'b1;
    check("b_rd_out", 32'(ib.data_out), 32'hBEEF);
    check("b_rd_oe",  32'(ib.data_oe), 1);
    tick();
    check("b_idle_oe", 32'(ib.data_oe), 0);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_ram_ctrl.md
Name: sap_ram_ctrl

Overview:
Parametrised single-port RAM for the SAP-style bus CPU, the next generation of the 16-byte MAR-addressed RAM.
- Generalises data width and depth.
- Registers a bus-drive enable alongside read data.
- Adds a reset-time clear sequencer.
- Adds a streaming program-load port with an auto-incrementing address, so a host can fill memory before the CPU runs.

Parameters:
DATA_WIDTH, 8, width of every memory word and data port.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words (derived, not overridable).
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to RUN with contents undefined.

Ports:
clk  in  1  sole clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
mar  in  ADDR_WIDTH  CPU address from the memory address register.
data_in  in  DATA_WIDTH  CPU write data.
ce_n  in  1  active-low chip enable; RAM drives the bus.
lr_n  in  1  active-low load RAM; CPU write.
data_out  out  DATA_WIDTH  registered read data.
data_oe  out  1  registered; high while data_out is valid bus data.
prog_en  in  1  request program-load mode.
prog_valid  in  1  prog_data valid.
prog_data  in  DATA_WIDTH  load word.
prog_ready  out  1  block accepts prog_data this cycle.
prog_addr  out  ADDR_WIDTH  address the next accepted load word is written to.
busy  out  1  high in CLEAR or PROG; CPU accesses are ignored.

Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:

Reset (rst high, effective immediately):
- data_out=0, data_oe=0, prog_ptr=0, clr_ptr=0.
- State = CLEAR if CLEAR_ON_RESET, else RUN.
- busy=1 in CLEAR.
- Reset asserted mid-CLEAR or mid-PROG aborts; the clear restarts from address 0 after release.

States and transitions:
- CLEAR: each cycle writes 0 to mem[clr_ptr], then clr_ptr++.
  - On the cycle that writes DEPTH-1, next state = RUN.
  - Takes exactly DEPTH cycles; busy=1 throughout.
  - prog_en, ce_n and lr_n are ignored.
- RUN, priority order:
  1. lr_n=0: mem[mar] <= data_in; data_oe <= 0; data_out holds.
  2. Else ce_n=0: data_out <= mem[mar]; data_oe <= 1. Latency is 1 cycle, so data is visible the cycle after ce_n is sampled low.
  3. Else: data_oe <= 0; data_out holds its last value.
  - Both lr_n and ce_n low: the write wins and no read occurs.
  - prog_en=1 sampled: next state = PROG, prog_ptr <= 0, data_oe <= 0. CPU inputs on that same cycle are still serviced.
- PROG:
  - prog_ready=1 (decoded combinationally from state only, never from prog_valid); busy=1; data_oe=0.
  - CPU inputs are ignored.
  - prog_valid=1 writes mem[prog_ptr] <= prog_data, then prog_ptr++.
  - prog_ptr wraps from DEPTH-1 to 0; the wrap overwrites without error.
  - prog_en=0 sampled: next state = RUN. A prog_valid on that same cycle is still accepted.
  - prog_addr = prog_ptr at all times; prog_addr = 0 outside PROG.

Outputs:
- busy = (state != RUN).
- prog_ready = (state == PROG).

Memory:
- Plain register array; no reset on the array itself, only via the CLEAR pass.
- Exactly one write port; at most one write per cycle, by construction of the states.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DW=8, AW=4: busy high exactly 16 cycles after rst falls. Then ce_n=0, mar=0..15 gives data_out=0x00 each read, data_oe=1 one cycle after each request.
- RUN write/read: lr_n=0, mar=3, data_in=0xA5, then lr_n=1, ce_n=0, mar=3 -> next cycle data_out=0xA5, data_oe=1. ce_n=1 -> data_oe=0, data_out stays 0xA5.
- Both lr_n=0 and ce_n=0, mar=7, data_in=0x3C -> mem[7]=0x3C, data_oe=0. A following read of mar=7 returns 0x3C.
- PROG stream: prog_en=1 then 18 valid words 0x10..0x21 -> prog_addr wraps 15->0. A read-back in RUN gives mem[0]=0x20, mem[1]=0x21, mem[2]=0x12, mem[15]=0x1F. A CPU write attempted during PROG (lr_n=0, mar=5, data_in=0xFF) leaves mem[5]=0x15.
- Reset mid-PROG after 5 words: rst pulse -> prog_ptr=0, data_oe=0, busy=1 for 16 cycles. All words read back 0x00.
- CLEAR_ON_RESET=0, DW=16, AW=6: busy=0 the first cycle after reset. Write 0xBEEF at mar=63 and read back 0xBEEF with 1-cycle latency.
